// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types for the pipeline stall/flush sequencer
package pipe_ctrl_pkg;

    localparam int PERF_CNT_W = 32;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        IWAIT = 2'd1,
        DWAIT = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic en;
        logic bubble;
    } stage_ctrl_t;

endpackage

// File: rtl/seq_watchdog.sv
// rtl/seq_watchdog.sv - wait-state cycle counter with sticky timeout flag
module seq_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_tick,
    output logic o_timeout
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          r_timeout;

    // Flag is raised on the cycle that completes the TIMEOUT_CYCLES-th wait cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (i_clear) begin
                r_cnt <= '0;
            end else if (i_tick && r_cnt != LIMIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (i_tick && !i_clear && r_cnt == LAST) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign o_timeout = r_timeout;

endmodule

// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - stall/flush sequencer for the 5-stage RV32 pipeline
// Optional: PIPE_PERF_CNT_EN enables the saturating perf_* counters.
module pipeline_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = PERF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_use_stall,
    input  logic             redirect_valid,
    input  logic             icache_miss,
    input  logic             icache_ready,
    input  logic             dcache_miss,
    input  logic             dcache_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_bubble,
    output logic             id_ex_bubble,
    output logic             ex_mem_bubble,
    output logic             icache_abort,
    output logic             timeout_err,
    output logic [CNT_W-1:0] perf_cycles,
    output logic [CNT_W-1:0] perf_lu_stalls,
    output logic [CNT_W-1:0] perf_imiss_cycles,
    output logic [CNT_W-1:0] perf_dmiss_cycles,
    output logic [CNT_W-1:0] perf_flushes
);

    seq_state_t  r_state, w_next;
    logic        r_ipend, w_ipend_next;
    logic        w_pc_en, w_mem_wb_en, w_abort;
    stage_ctrl_t w_if_id, w_id_ex, w_ex_mem;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
            r_ipend <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ipend <= w_ipend_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_ipend_next = r_ipend;
        w_pc_en      = 1'b1;
        w_mem_wb_en  = 1'b1;
        w_abort      = 1'b0;
        w_if_id      = '{en: 1'b1, bubble: 1'b0};
        w_id_ex      = '{en: 1'b1, bubble: 1'b0};
        w_ex_mem     = '{en: 1'b1, bubble: 1'b0};

        if (r_state == DWAIT || dcache_miss) begin
            if (r_state == DWAIT && dcache_ready) begin
                w_next       = (r_ipend && !icache_ready) ? IWAIT : RUN;
                w_ipend_next = 1'b0;
            end else begin
                w_pc_en     = 1'b0;
                w_mem_wb_en = 1'b0;
                w_if_id.en  = 1'b0;
                w_id_ex.en  = 1'b0;
                w_ex_mem.en = 1'b0;
                w_next      = DWAIT;
                // Remember an I$ wait interrupted by the D$ miss unless its fill lands now.
                if (r_state != DWAIT) begin
                    w_ipend_next = (r_state == IWAIT || icache_miss) && !icache_ready;
                end else if (icache_ready) begin
                    w_ipend_next = 1'b0;
                end
            end
        end else if (redirect_valid && !load_use_stall) begin
            w_if_id.bubble = 1'b1;
            w_id_ex.bubble = 1'b1;
            if (r_state == IWAIT) begin
                w_abort = 1'b1;
                w_next  = RUN;
            end
        end else if (load_use_stall) begin
            w_pc_en         = 1'b0;
            w_if_id.en      = 1'b0;
            w_id_ex.en      = 1'b0;
            w_ex_mem.bubble = 1'b1;
        end else if (r_state == IWAIT && icache_ready) begin
            w_next = RUN;
        end else if (r_state == IWAIT || icache_miss) begin
            w_pc_en        = 1'b0;
            w_if_id.bubble = 1'b1;
            w_next         = IWAIT;
        end

        if (reset) begin
            w_pc_en     = 1'b0;
            w_mem_wb_en = 1'b0;
            w_abort     = 1'b0;
            w_if_id     = '{en: 1'b0, bubble: 1'b1};
            w_id_ex     = '{en: 1'b0, bubble: 1'b1};
            w_ex_mem    = '{en: 1'b0, bubble: 1'b1};
        end
    end

    assign pc_en         = w_pc_en;
    assign if_id_en      = w_if_id.en;
    assign id_ex_en      = w_id_ex.en;
    assign ex_mem_en     = w_ex_mem.en;
    assign mem_wb_en     = w_mem_wb_en;
    assign if_id_bubble  = w_if_id.bubble;
    assign id_ex_bubble  = w_id_ex.bubble;
    assign ex_mem_bubble = w_ex_mem.bubble;
    assign icache_abort  = w_abort;

    seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst      (reset),
        .i_clear  ((r_state == RUN) || (w_next != r_state)),
        .i_tick   (r_state != RUN),
        .o_timeout(timeout_err)
    );

`ifdef PIPE_PERF_CNT_EN
    logic             w_frozen, w_lu_acc, w_flush;
    logic [CNT_W-1:0] r_cycles, r_lu, r_imiss, r_dmiss, r_flushes;

    assign w_frozen = (r_state == DWAIT) || dcache_miss;
    assign w_lu_acc = !w_frozen && load_use_stall;
    assign w_flush  = !w_frozen && redirect_valid && !load_use_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycles  <= '0;
            r_lu      <= '0;
            r_imiss   <= '0;
            r_dmiss   <= '0;
            r_flushes <= '0;
        end else begin
            if (!(&r_cycles))                         r_cycles  <= r_cycles + 1'b1;
            if (w_lu_acc && !(&r_lu))                 r_lu      <= r_lu + 1'b1;
            if (r_state == IWAIT && !(&r_imiss))      r_imiss   <= r_imiss + 1'b1;
            if (r_state == DWAIT && !(&r_dmiss))      r_dmiss   <= r_dmiss + 1'b1;
            if (w_flush && !(&r_flushes))             r_flushes <= r_flushes + 1'b1;
        end
    end

    assign perf_cycles       = r_cycles;
    assign perf_lu_stalls    = r_lu;
    assign perf_imiss_cycles = r_imiss;
    assign perf_dmiss_cycles = r_dmiss;
    assign perf_flushes      = r_flushes;
`else
    assign perf_cycles       = '0;
    assign perf_lu_stalls    = '0;
    assign perf_imiss_cycles = '0;
    assign perf_dmiss_cycles = '0;
    assign perf_flushes      = '0;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb/tb_pipeline_sequencer.sv - directed scoreboard bench for pipeline_sequencer
module tb_pipeline_sequencer;

    localparam int CW = 32;

    // {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id/id_ex/ex_mem bubbles, abort, timeout}
    localparam logic [9:0] RST_V  = 10'b00000_111_0_0;
    localparam logic [9:0] NORM   = 10'b11111_000_0_0;
    localparam logic [9:0] LU     = 10'b00011_001_0_0;
    localparam logic [9:0] IMISS  = 10'b01111_100_0_0;
    localparam logic [9:0] FRZ    = 10'b00000_000_0_0;
    localparam logic [9:0] REDIR  = 10'b11111_110_0_0;
    localparam logic [9:0] REDIRA = 10'b11111_110_1_0;
    localparam logic [9:0] ERR    = 10'b00000_000_0_1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic load_use_stall = 1'b0, redirect_valid = 1'b0;
    logic icache_miss = 1'b0, icache_ready = 1'b0;
    logic dcache_miss = 1'b0, dcache_ready = 1'b0;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_bubble, id_ex_bubble, ex_mem_bubble, icache_abort, timeout_err;
    logic [CW-1:0] perf_cycles, perf_lu_stalls, perf_imiss_cycles, perf_dmiss_cycles, perf_flushes;

    logic [9:0] sb_q[$];
    string      tag_q[$];
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    pipeline_sequencer #(
        .TIMEOUT_CYCLES(8),
        .CNT_W         (CW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .load_use_stall   (load_use_stall),
        .redirect_valid   (redirect_valid),
        .icache_miss      (icache_miss),
        .icache_ready     (icache_ready),
        .dcache_miss      (dcache_miss),
        .dcache_ready     (dcache_ready),
        .pc_en            (pc_en),
        .if_id_en         (if_id_en),
        .id_ex_en         (id_ex_en),
        .ex_mem_en        (ex_mem_en),
        .mem_wb_en        (mem_wb_en),
        .if_id_bubble     (if_id_bubble),
        .id_ex_bubble     (id_ex_bubble),
        .ex_mem_bubble    (ex_mem_bubble),
        .icache_abort     (icache_abort),
        .timeout_err      (timeout_err),
        .perf_cycles      (perf_cycles),
        .perf_lu_stalls   (perf_lu_stalls),
        .perf_imiss_cycles(perf_imiss_cycles),
        .perf_dmiss_cycles(perf_dmiss_cycles),
        .perf_flushes     (perf_flushes)
    );

    wire [9:0] w_obs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                        if_id_bubble, id_ex_bubble, ex_mem_bubble, icache_abort, timeout_err};

    task automatic cyc(input string tag, input logic rst_i, input logic lu, input logic rd,
                       input logic im, input logic ir, input logic dm, input logic dr,
                       input logic [9:0] exp);
        logic [9:0] want;
        string      t;
        @(posedge clk);
        #1;
        reset          = rst_i;
        load_use_stall = lu;
        redirect_valid = rd;
        icache_miss    = im;
        icache_ready   = ir;
        dcache_miss    = dm;
        dcache_ready   = dr;
        sb_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        want = sb_q.pop_front();
        t    = tag_q.pop_front();
        n_tests++;
        assert (w_obs === want) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", t, w_obs, want);
        end
    endtask

    initial begin
        cyc("reset_state", 1, 0, 0, 0, 0, 0, 0, RST_V);
        cyc("first_run",   0, 0, 0, 0, 0, 0, 0, NORM);

        cyc("lu_stall",    0, 1, 0, 0, 0, 0, 0, LU);
        cyc("lu_release",  0, 0, 0, 0, 0, 0, 0, NORM);

        for (int i = 0; i < 5; i++) cyc("imiss_wait", 0, 0, 0, 1, 0, 0, 0, IMISS);
        cyc("iready",      0, 0, 0, 0, 1, 0, 0, NORM);
        cyc("iready_run",  0, 0, 0, 0, 0, 0, 0, NORM);

        cyc("imiss_enter", 0, 0, 0, 1, 0, 0, 0, IMISS);
        for (int i = 0; i < 3; i++) cyc("dmiss_in_iwait", 0, 0, 0, 1, 0, 1, 0, FRZ);
        cyc("dready",      0, 0, 0, 0, 0, 0, 1, NORM);
        cyc("back_iwait",  0, 0, 0, 0, 0, 0, 0, IMISS);

        cyc("redir_iwait", 0, 0, 1, 0, 0, 0, 0, REDIRA);
        cyc("redir_run",   0, 0, 0, 0, 0, 0, 0, NORM);
        cyc("redir_in_run",0, 0, 1, 1, 0, 0, 0, REDIR);
        cyc("redir_no_iw", 0, 0, 0, 0, 0, 0, 0, NORM);

        cyc("redir_lu",    0, 1, 1, 0, 0, 0, 0, LU);
        cyc("redir_lu_nx", 0, 0, 0, 0, 0, 0, 0, NORM);

        cyc("iw_for_race", 0, 0, 0, 1, 0, 0, 0, IMISS);
        cyc("iready_dmiss",0, 0, 0, 0, 1, 1, 0, FRZ);
        cyc("dready_race", 0, 0, 0, 0, 0, 0, 1, NORM);
        cyc("race_to_run", 0, 0, 0, 0, 0, 0, 0, NORM);

        cyc("iw_for_rst",  0, 0, 0, 1, 0, 0, 0, IMISS);
        cyc("iw_hold",     0, 0, 0, 0, 0, 0, 0, IMISS);
        cyc("rst_mid",     1, 0, 0, 0, 0, 0, 0, RST_V);
        cyc("rst_to_run",  0, 0, 0, 0, 0, 0, 0, NORM);

        cyc("wd_enter",    0, 0, 0, 0, 0, 1, 0, FRZ);
        for (int i = 0; i < 8; i++) cyc("wd_pre", 0, 0, 0, 0, 0, 1, 0, FRZ);
        for (int i = 0; i < 3; i++) cyc("wd_timeout", 0, 0, 0, 0, 0, 1, 0, FRZ | ERR);
        cyc("wd_dready",   0, 0, 0, 0, 0, 0, 1, NORM | ERR);
        cyc("wd_sticky",   0, 0, 0, 0, 0, 0, 0, NORM | ERR);

        n_tests++;
`ifdef PIPE_PERF_CNT_EN
        assert (perf_dmiss_cycles >= 8 && perf_lu_stalls == 2 && perf_flushes == 2) else begin
            n_fail++;
            $error("FAIL perf_counters observed=dmiss %0d lu %0d flush %0d expected=dmiss>=8 lu 2 flush 2",
                   perf_dmiss_cycles, perf_lu_stalls, perf_flushes);
        end
`else
        assert ((perf_cycles | perf_lu_stalls | perf_imiss_cycles | perf_dmiss_cycles | perf_flushes) === '0) else begin
            n_fail++;
            $error("FAIL perf_tied_zero observed=cycles %0d dmiss %0d expected=0",
                   perf_cycles, perf_dmiss_cycles);
        end
`endif

        cyc("wd_reset",    1, 0, 0, 0, 0, 0, 0, RST_V);
        cyc("wd_cleared",  0, 0, 0, 0, 0, 0, 0, NORM);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
